// File: rtl/lava_pkg.sv
// Shared types and geometry for the double-buffered frame-buffer controller.
package lava_pkg;

  localparam int COLS   = 64;
  localparam int ROWS   = 32;
  localparam int DATA_W = 12;
  localparam int HALF_D = COLS * ROWS / 2;
  localparam int AW     = $clog2(HALF_D);

  // {R[11:8], G[7:4], B[3:0]}
  typedef logic [DATA_W-1:0] pixel_t;

  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } fb_state_e;

endpackage

// File: rtl/fb_swap_ctrl_if.sv
// Writer stream and display read port of the frame-buffer controller.
interface fb_swap_ctrl_if;
  import lava_pkg::*;

  logic [AW-1:0] r_addr;
  pixel_t        din_top;
  pixel_t        din_btm;
  logic          wr_valid;
  logic          wr_ready;
  pixel_t        wr_data;
  logic          wr_last;
  logic          swap;
  logic          disp_ok;
  logic          wr_err;

  modport master (
    output r_addr, wr_valid, wr_data, wr_last,
    input  din_top, din_btm, wr_ready, swap, disp_ok, wr_err
  );

  modport slave (
    input  r_addr, wr_valid, wr_data, wr_last,
    output din_top, din_btm, wr_ready, swap, disp_ok, wr_err
  );

endinterface

// File: rtl/fb_ram.sv
// Simple dual-port HALF_D x DATA_W RAM: one write port, one registered read port.
module fb_ram
  import lava_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pixel_t        wdata,
  input  logic [AW-1:0] raddr,
  output pixel_t        rdata
);

  pixel_t mem [HALF_D];
  pixel_t rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fb_swap_ctrl.sv
// Double-buffered frame store: writer fills the back bank, display reads the front
// bank, and the banks exchange only on a display frame wrap.
module fb_swap_ctrl
  import lava_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  fb_swap_ctrl_if.slave bus
);

  localparam logic [AW:0]   PIX_MAX  = '1;
  localparam logic [AW-1:0] ADDR_MAX = '1;

  fb_state_e     state_q, state_d;
  logic          front_q, front_d;
  logic [AW:0]   pix_cnt_q, pix_cnt_d;
  logic [AW-1:0] prev_addr_q, prev_addr_d;
  logic          disp_ok_q, disp_ok_d;
  logic          wr_err_q, wr_err_d;
  logic          rd_bank_q, rd_bank_d;

  logic          wrap;
  logic          wr_ready;
  logic          swap_pls;
  logic          xfer;
  logic          wr_bank;

  assign wrap = (prev_addr_q == ADDR_MAX) && (bus.r_addr == '0);

  always_comb begin
    state_d     = state_q;
    front_d     = front_q;
    pix_cnt_d   = pix_cnt_q;
    disp_ok_d   = disp_ok_q;
    wr_err_d    = wr_err_q;
    prev_addr_d = bus.r_addr;
    wr_ready    = 1'b0;
    swap_pls    = 1'b0;

    case (state_q)
      FILL: begin
        wr_ready = 1'b1;
        if (bus.wr_valid) begin
          if (pix_cnt_q == PIX_MAX) begin
            state_d   = PEND;
            pix_cnt_d = '0;
            if (!bus.wr_last) wr_err_d = 1'b1;
          end else if (bus.wr_last) begin
            // short frame: restart so the partial frame gets overwritten
            wr_err_d  = 1'b1;
            pix_cnt_d = '0;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      PEND: begin
        if (wrap) begin
          front_d   = ~front_q;
          swap_pls  = 1'b1;
          disp_ok_d = 1'b1;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    // the read of address 0 on the swap cycle already sees the new front bank
    rd_bank_d = front_q ^ swap_pls;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      front_q     <= 1'b0;
      pix_cnt_q   <= '0;
      prev_addr_q <= '0;
      disp_ok_q   <= 1'b0;
      wr_err_q    <= 1'b0;
      rd_bank_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_q     <= front_d;
      pix_cnt_q   <= pix_cnt_d;
      prev_addr_q <= prev_addr_d;
      disp_ok_q   <= disp_ok_d;
      wr_err_q    <= wr_err_d;
      rd_bank_q   <= rd_bank_d;
    end
  end

  assign xfer    = bus.wr_valid && wr_ready;
  assign wr_bank = ~front_q;

  pixel_t rd_data [2][2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar h = 0; h < 2; h++) begin : g_half
      logic we;
      assign we = xfer && (wr_bank == 1'(b)) && (pix_cnt_q[AW] == 1'(h));

      fb_ram u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (pix_cnt_q[AW-1:0]),
        .wdata (bus.wr_data),
        .raddr (bus.r_addr),
        .rdata (rd_data[b][h])
      );
    end
  end

  assign bus.din_top  = rd_data[rd_bank_q][0];
  assign bus.din_btm  = rd_data[rd_bank_q][1];
  assign bus.wr_ready = wr_ready;
  assign bus.swap     = swap_pls;
  assign bus.disp_ok  = disp_ok_q;
  assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed bench for fb_swap_ctrl: reset, fill/swap, backpressure, same-cycle wrap,
// short frame and bank isolation.
module tb_fb_swap_ctrl;

  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  fb_swap_ctrl_if bus();

  fb_swap_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic logic [11:0] pix(input int kind, input int i);
    int v;
    case (kind)
      1:       v = i;
      2:       v = i * 3 + 7;
      default: v = i ^ 32'h555;
    endcase
    return 12'(v & 4095);
  endfunction

  task automatic write_frame(input int n, input int kind, input bit with_last);
    for (int i = 0; i < n; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = pix(kind, i);
      bus.wr_last  = with_last && (i == n - 1);
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
  endtask

  task automatic do_wrap_swap(input string tag);
    bus.r_addr = 10'd1023;
    tick();
    bus.r_addr = 10'd0;
    mid();
    chk(tag, bus.swap, 1);
    tick();
  endtask

  initial begin
    rst          = 1'b1;
    bus.r_addr   = '0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.wr_last  = 1'b0;
    #2;
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_swap",     bus.swap,     0);
    chk("rst_disp_ok",  bus.disp_ok,  0);
    chk("rst_wr_err",   bus.wr_err,   0);
    chk("rst_pix_cnt",  dut.pix_cnt_q, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // T1: async reset in the middle of a fill
    write_frame(500, 1, 1'b0);
    chk("t1_pix_cnt_500", dut.pix_cnt_q, 500);
    #2 rst = 1'b1;
    #1;
    chk("t1_pix_cnt_async", dut.pix_cnt_q, 0);
    chk("t1_wr_ready",      bus.wr_ready,  1);
    chk("t1_disp_ok",       bus.disp_ok,   0);
    chk("t1_swap",          bus.swap,      0);
    tick();
    rst = 1'b0;
    tick();

    // T2: full frame then swap on the display wrap
    write_frame(2048, 1, 1'b1);
    mid();
    chk("t2_pend_ready", bus.wr_ready, 0);
    chk("t2_wr_err",     bus.wr_err,   0);
    chk("t2_no_ok_yet",  bus.disp_ok,  0);
    do_wrap_swap("t2_swap");
    chk("t2_disp_ok",    bus.disp_ok,  1);
    chk("t2_swap_pulse", bus.swap,     0);
    chk("t2_top_a0",     bus.din_top,  0);
    chk("t2_btm_a0",     bus.din_btm,  1024);
    bus.r_addr = 10'd5;
    tick();
    chk("t2_top_a5",     bus.din_top,  5);
    chk("t2_btm_a5",     bus.din_btm,  1029);

    // T6 + T4: fill frame 2 while sweeping reads; last pixel lands on a wrap
    for (int i = 0; i < 2048; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = pix(2, i);
      bus.wr_last  = (i == 2047);
      bus.r_addr   = 10'((i + 1) & 1023);
      if (i == 2047) begin
        mid();
        chk("t4_no_swap_same_cycle", bus.swap, 0);
      end
      tick();
      chk("t6_iso_top", bus.din_top, 32'(pix(1, (i + 1) & 1023)));
      chk("t6_iso_btm", bus.din_btm, 32'(pix(1, 1024 + ((i + 1) & 1023))));
    end
    bus.wr_last = 1'b0;
    mid();
    chk("t4_pend_after_last", bus.wr_ready, 0);

    // T3: writer keeps pushing with no wrap; must stay stalled
    bus.wr_valid = 1'b1;
    bus.wr_data  = 12'hFFF;
    for (int k = 0; k < 5000; k++) begin
      tick();
      bus.r_addr = 10'(1 + (k % 1000));
      mid();
      chk("t3_ready_low", bus.wr_ready, 0);
      chk("t3_no_swap",   bus.swap,     0);
    end
    tick();
    do_wrap_swap("t4_swap_next_wrap");
    bus.wr_valid = 1'b0;
    chk("t3_top_a0_untouched", bus.din_top, 32'(pix(2, 0)));
    chk("t3_btm_a0",           bus.din_btm, 32'(pix(2, 1024)));
    mid();
    chk("t3_ready_after_wrap", bus.wr_ready, 1);
    tick();
    bus.r_addr = 10'd5;
    tick();
    chk("t3_top_a5", bus.din_top, 32'(pix(2, 5)));
    chk("t3_btm_a5", bus.din_btm, 32'(pix(2, 1029)));

    // T5: short frame flagged and discarded, next full frame still swaps
    write_frame(101, 3, 1'b1);
    mid();
    chk("t5_wr_err",    bus.wr_err,     1);
    chk("t5_pix_cnt",   dut.pix_cnt_q,  0);
    chk("t5_no_pend",   bus.wr_ready,   1);
    tick();
    write_frame(2048, 3, 1'b1);
    mid();
    chk("t5_pend", bus.wr_ready, 0);
    tick();
    do_wrap_swap("t5_swap");
    chk("t5_top_a0",      bus.din_top, 32'(pix(3, 0)));
    chk("t5_btm_a0",      bus.din_btm, 32'(pix(3, 1024)));
    chk("t5_err_sticky",  bus.wr_err,  1);
    bus.r_addr = 10'd1000;
    tick();
    chk("t5_top_a1000",   bus.din_top, 32'(pix(3, 1000)));
    chk("t5_btm_a1000",   bus.din_btm, 32'(pix(3, 2024)));

    // reset while a completed frame is pending
    write_frame(2048, 1, 1'b1);
    mid();
    chk("rst2_pend", bus.wr_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst2_wr_ready", bus.wr_ready, 1);
    chk("rst2_disp_ok",  bus.disp_ok,  0);
    chk("rst2_wr_err",   bus.wr_err,   0);
    chk("rst2_swap",     bus.swap,     0);
    chk("rst2_front",    dut.front_q,  0);
    chk("rst2_pix_cnt",  dut.pix_cnt_q, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
